// File: rtl/kab_uart_rx.sv
// kab_uart_rx: 8N1 serial receiver with a small byte FIFO, level interrupt and sticky error flags.
module kab_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Din,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxRead,
    output logic       RxIntReq,
    output logic       FrameErr,
    output logic       Overrun,
    input  logic       ErrClr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t state_q, state_d;
    logic sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [7:0] mem_d [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic s, push_req, frame_set, empty, full, pop, push_ok;
    assign s = sync2_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        push_req = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: if (!s) begin
                state_d = START;
                cnt_d = '0;
            end
            START: if (cnt_q == HALF_M1) begin
                state_d = s ? IDLE : DATA;
                cnt_d = '0;
                bit_d = '0;
            end
            DATA: if (cnt_q == LAST) begin
                shift_d = {s, shift_q[7:1]};
                cnt_d = '0;
                bit_d = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == LAST) begin
                push_req = s;
                frame_set = !s;
                state_d = s ? IDLE : BRK;
            end
            BRK: state_d = s ? IDLE : BRK;
            default: state_d = IDLE;
        endcase
    end
    // Extra pointer bit tells full from empty when the index bits match.
    always_comb begin
        empty = (wr_q == rd_q);
        full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop = RxRead && !empty;
        push_ok = push_req && (!full || pop);
        wr_d = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q[AW-1:0]] = shift_q;
        frame_err_d = frame_set | (frame_err_q & ~ErrClr);
        overrun_d = (push_req & full & ~pop) | (overrun_q & ~ErrClr);
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            frame_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q <= Din;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            frame_err_q <= frame_err_d;
            overrun_q <= overrun_d;
        end
    end
    assign RxData = mem_q[rd_q[AW-1:0]];
    assign RxValid = !empty;
    assign RxIntReq = !empty;
    assign FrameErr = frame_err_q;
    assign Overrun = overrun_q;
endmodule

// File: tb/tb_kab_uart_rx.sv
// tb_kab_uart_rx: directed checks of kab_uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_kab_uart_rx;
    localparam int CPB = 16;
    logic Clock = 1'b0;
    logic Reset, Din, RxRead, ErrClr;
    logic [7:0] RxData;
    logic RxValid, RxIntReq, FrameErr, Overrun;
    int checks = 0;
    int failures = 0;
    int lat;
    kab_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .Clock(Clock), .Reset(Reset), .Din(Din), .RxData(RxData), .RxValid(RxValid),
        .RxRead(RxRead), .RxIntReq(RxIntReq), .FrameErr(FrameErr), .Overrun(Overrun),
        .ErrClr(ErrClr)
    );
    always #5 Clock = ~Clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stop);
        Din = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            Din = b[i];
            tick(CPB);
        end
        Din = stop;
        tick(CPB);
    endtask
    task automatic pop();
        RxRead = 1'b1;
        tick(1);
        RxRead = 1'b0;
    endtask
    task automatic clr();
        ErrClr = 1'b1;
        tick(1);
        ErrClr = 1'b0;
    endtask
    initial begin
        Reset = 1'b1;
        Din = 1'b1;
        RxRead = 1'b0;
        ErrClr = 1'b0;
        tick(3);
        Reset = 1'b0;
        tick(2);
        check("rst_valid", RxValid, 0);
        check("rst_irq", RxIntReq, 0);
        check("rst_ferr", FrameErr, 0);
        check("rst_ovr", Overrun, 0);
        check("rst_data", RxData, 8'h00);
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            for (int n = 1; n <= 200 && lat == 0; n++) begin
                tick(1);
                if (RxValid) lat = n;
            end
        join
        check("a5_latency_window", (lat >= 154 && lat <= 156), 1);
        check("a5_data", RxData, 8'hA5);
        check("a5_irq", RxIntReq, 1);
        pop();
        check("a5_popped", RxValid, 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        check("b2b_0", RxData, 8'h00);
        pop();
        check("b2b_1", RxData, 8'hFF);
        pop();
        check("b2b_2", RxData, 8'h3C);
        pop();
        check("b2b_empty", RxValid, 0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        check("ovr_set", Overrun, 1);
        clr();
        check("ovr_clr", Overrun, 0);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_keep", RxData, 8'(i));
            pop();
        end
        check("ovr_empty", RxValid, 0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        fork
            send_byte(8'h05, 1'b1);
            begin
                tick(154);
                RxRead = 1'b1;
                tick(1);
                RxRead = 1'b0;
            end
        join
        check("rdpush_no_ovr", Overrun, 0);
        for (int i = 2; i <= 5; i++) begin
            check("rdpush_data", RxData, 8'(i));
            pop();
        end
        check("rdpush_empty", RxValid, 0);
        send_byte(8'h55, 1'b0);
        Din = 1'b0;
        tick(20 * CPB);
        check("brk_ferr", FrameErr, 1);
        check("brk_nopush", RxValid, 0);
        clr();
        tick(20 * CPB);
        check("brk_single_err", FrameErr, 0);
        Din = 1'b1;
        tick(20);
        send_byte(8'h5A, 1'b1);
        check("brk_after_data", RxData, 8'h5A);
        check("brk_after_ferr", FrameErr, 0);
        pop();
        check("brk_after_empty", RxValid, 0);
        Din = 1'b0;
        tick(4);
        Din = 1'b1;
        tick(200);
        check("glitch_valid", RxValid, 0);
        check("glitch_ferr", FrameErr, 0);
        check("glitch_ovr", Overrun, 0);
        send_byte(8'h11, 1'b1);
        check("pre_rst_valid", RxValid, 1);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                tick(88);
                Reset = 1'b1;
                tick(2);
                Reset = 1'b0;
                check("midrst_flushed", RxValid, 0);
            end
        join
        tick(20);
        send_byte(8'hC3, 1'b1);
        check("midrst_data", RxData, 8'hC3);
        check("midrst_ferr", FrameErr, 0);
        check("midrst_ovr", Overrun, 0);
        pop();
        check("midrst_single", RxValid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kab_uart_rx.md
Name: kab_uart_rx

Overview:
- Serial receive port for the Kabeta SystemChip; the inbound counterpart of the chip's Dout serial transmit line.
- Deserialises 8N1 asynchronous frames from Din, LSB first, idle-high.
- Buffers received bytes in a small FIFO and presents them to the core with a read-strobe handshake.
- Raises a level interrupt request while data is pending; flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal values are 4 or more.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, legal range 2..16.

Ports:
- Clock  input  1  system clock; all logic is rising-edge.
- Reset  input  1  synchronous, active-high reset.
- Din  input  1  asynchronous serial input; idle is 1.
- RxData  output  8  byte at the FIFO head; valid only while RxValid=1.
- RxValid  output  1  FIFO not empty.
- RxRead  input  1  one-cycle pop strobe; ignored when RxValid=0.
- RxIntReq  output  1  interrupt request; equal to RxValid.
- FrameErr  output  1  sticky; a stop bit was sampled 0.
- Overrun  output  1  sticky; a valid byte arrived while the FIFO was full.
- ErrClr  input  1  clears FrameErr and Overrun.

Behaviour:
- Reset values
  - RxValid=0, RxIntReq=0, FrameErr=0, Overrun=0, RxData=8'h00.
  - FIFO is emptied; state is IDLE.
  - Both synchroniser stages are set to 1.
  - Reset asserted mid-frame abandons the frame; no push and no error results.
- Input path: Din passes through a 2-FF synchroniser; all following logic uses the synchronised value S.
- Bit counter: 0..CLKS_PER_BIT-1. H = CLKS_PER_BIT/2, integer division.
- State machine
  - IDLE: when S=0, go to START and clear the counter.
  - START: at counter = H-1, sample S.
    - S=1: glitch; return to IDLE with no flags.
    - S=0: clear the counter and go to DATA.
  - DATA: each time counter = CLKS_PER_BIT-1, sample S into shift[bit], bit = 0..7, LSB first, then clear the counter. After bit 7, go to STOP.
  - STOP: at counter = CLKS_PER_BIT-1, sample S.
    - S=1: push the byte (or set Overrun if full), then go to IDLE.
    - S=0: set FrameErr, discard the byte, go to BREAK.
    - Sampling is mid-stop-bit; the receiver re-arms immediately without waiting for the stop bit to end.
  - BREAK: wait until S=1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- FIFO
  - RxData is read combinationally from storage at the read pointer.
  - A push takes effect at the clock edge after the stop sample; RxValid rises one cycle later.
  - On RxRead with RxValid=1, the read pointer advances; the next byte appears on RxData in the following cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy uses an extra bit to distinguish full from empty.
- Simultaneous events
  - Push and RxRead on a full FIFO: the pop frees a slot, the push succeeds, occupancy stays full, no Overrun.
  - Push and RxRead on an empty FIFO: the push succeeds and the read is ignored.
  - Push on a full FIFO without RxRead: byte dropped, Overrun=1, FIFO contents unchanged.
  - ErrClr in the same cycle as a new error event: the flag ends set.
- Latency: RxValid rises 2+H+9*CLKS_PER_BIT+1 cycles (±1) after the Din falling edge of the start bit.

Test Plan:
- CLKS_PER_BIT=16; send 8'hA5 framed 0,10100101(LSB first),1 -> RxValid=1 within the latency window, RxData=8'hA5, RxIntReq=1; RxRead pulse -> RxValid=0 next cycle.
- Send 8'h00, 8'hFF, 8'h3C back to back with no extra idle -> three entries in order; three RxRead pulses yield 00, FF, 3C, then RxValid=0.
- FIFO_DEPTH=4, send 5 bytes 01..05 with no reads -> FIFO holds 01..04, Overrun=1; ErrClr -> Overrun=0. Repeat with RxRead asserted exactly on the 5th push cycle -> no Overrun, FIFO holds 02..05.
- Frame 8'h55 with stop bit 0, then hold Din low 40 bit times -> FrameErr=1, no push, a single error only; release Din and send 8'h5A -> RxData=8'h5A.
- Din low pulse of 4 cycles (less than H) -> no frame started, no flags, RxValid stays 0.
- Assert Reset midway through the data bits of a frame, release, then send 8'hC3 -> no spurious byte, RxData=8'hC3, flags 0.
